// File: rtl/divui_seq_if.sv
// divui_seq_if: joined operand channels and elastic result channel of the sequential divider
interface divui_seq_if #(parameter int DATA_TYPE = 32);
    logic [DATA_TYPE-1:0] lhs;
    logic                 lhs_valid;
    logic                 lhs_ready;
    logic [DATA_TYPE-1:0] rhs;
    logic                 rhs_valid;
    logic                 rhs_ready;
    logic [DATA_TYPE-1:0] result;
    logic                 result_valid;
    logic                 result_ready;
    modport master (
        output lhs, lhs_valid, rhs, rhs_valid, result_ready,
        input  lhs_ready, rhs_ready, result, result_valid
    );
    modport slave (
        input  lhs, lhs_valid, rhs, rhs_valid, result_ready,
        output lhs_ready, rhs_ready, result, result_valid
    );
endinterface

// File: rtl/divui_seq.sv
// divui_seq: radix-2 restoring unsigned divider, one quotient bit per cycle, one op in flight
module divui_seq #(parameter int DATA_TYPE = 32) (
    input logic        clk,
    input logic        rst,
    divui_seq_if.slave io
);
    localparam int CW = $clog2(DATA_TYPE + 1);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t               state, state_n;
    logic [DATA_TYPE-1:0] quo, div;
    logic [DATA_TYPE:0]   rem;
    logic [DATA_TYPE+1:0] sh, diff;
    logic [CW-1:0]        cnt;
    logic                 accept, fire;
    assign accept          = state == IDLE || (state == DONE && io.result_ready);
    assign fire            = accept && io.lhs_valid && io.rhs_valid;
    assign io.lhs_ready    = accept && io.rhs_valid;
    assign io.rhs_ready    = accept && io.lhs_valid;
    assign io.result       = quo;
    assign io.result_valid = state == DONE;
    assign sh              = {rem, quo[DATA_TYPE-1]};
    assign diff            = sh - {2'b00, div};
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    // next state: a fire in DONE goes straight back to BUSY
    always_comb begin
        state_n = fire                               ? BUSY :
                  (state == BUSY && cnt == CW'(1))   ? DONE :
                  (state == DONE && io.result_ready) ? IDLE : state;
    end
    // datapath: load operands on fire, then shift/trial-subtract each BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            quo <= '0;
            div <= '0;
            rem <= '0;
            cnt <= '0;
        end else if (fire) begin
            quo <= io.lhs;
            div <= io.rhs;
            rem <= '0;
            cnt <= CW'(DATA_TYPE);
        end else if (state == BUSY) begin
            quo <= {quo[DATA_TYPE-2:0], ~diff[DATA_TYPE+1]};
            rem <= diff[DATA_TYPE+1] ? sh[DATA_TYPE:0] : diff[DATA_TYPE:0];
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_divui_seq.sv
// tb_divui_seq: directed self-checking bench for divui_seq at DATA_TYPE = 8
module tb_divui_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    divui_seq_if #(.DATA_TYPE(8)) io ();
    divui_seq #(.DATA_TYPE(8)) dut (.clk(clk), .rst(rst), .io(io));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (io.result_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic op(input logic [7:0] a, input logic [7:0] b, input int exp, input string tag);
        int n;
        io.lhs = a;
        io.rhs = b;
        io.lhs_valid = 1'b1;
        io.rhs_valid = 1'b1;
        io.result_ready = 1'b1;
        #1 chk({tag, "_rdy"}, {30'd0, io.lhs_ready, io.rhs_ready}, 32'd3);
        tick();
        io.lhs_valid = 1'b0;
        io.rhs_valid = 1'b0;
        wait_valid(n);
        chk({tag, "_lat"}, n, 8);
        chk({tag, "_q"}, {24'd0, io.result}, exp);
    endtask

    initial begin
        int n;
        logic [7:0] ea [5] = '{8'd13, 8'd255, 8'd0, 8'd5, 8'd255};
        logic [7:0] eb [5] = '{8'd0, 8'd1, 8'd5, 8'd9, 8'd255};
        int         eq [5] = '{255, 255, 0, 0, 1};
        io.lhs = '0;
        io.rhs = '0;
        io.lhs_valid = 1'b0;
        io.rhs_valid = 1'b0;
        io.result_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, io.result_valid}, 0);
        chk("rst_result", {24'd0, io.result}, 0);
        io.lhs_valid = 1'b1;
        #1 chk("rst_join", {30'd0, io.lhs_ready, io.rhs_ready}, 32'd1);
        io.lhs_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_rdy", {30'd0, io.lhs_ready, io.rhs_ready}, 0);

        op(8'd100, 8'd7, 14, "basic");
        tick();
        chk("basic_drop", {31'd0, io.result_valid}, 0);

        for (int i = 0; i < 5; i++) begin
            op(ea[i], eb[i], eq[i], $sformatf("edge%0d", i));
            tick();
        end

        io.lhs = 8'd200;
        io.rhs = 8'd3;
        io.lhs_valid = 1'b1;
        io.rhs_valid = 1'b1;
        io.result_ready = 1'b0;
        tick();
        io.lhs = 8'd1;
        io.rhs = 8'd1;
        wait_valid(n);
        chk("bp_lat", n, 8);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, io.result_valid}, 1);
            chk("bp_q", {24'd0, io.result}, 66);
            chk("bp_rdy", {30'd0, io.lhs_ready, io.rhs_ready}, 0);
            tick();
        end
        io.result_ready = 1'b1;
        #1 chk("bp_hs_rdy", {30'd0, io.lhs_ready, io.rhs_ready}, 32'd3);
        tick();
        io.lhs_valid = 1'b0;
        io.rhs_valid = 1'b0;
        chk("bp_hs_drop", {31'd0, io.result_valid}, 0);
        wait_valid(n);
        chk("bp_next_lat", n, 8);
        chk("bp_next_q", {24'd0, io.result}, 1);
        tick();

        io.lhs = 8'd60;
        io.rhs = 8'd4;
        io.lhs_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("stag_rdy", {30'd0, io.lhs_ready, io.rhs_ready}, 32'd1);
            tick();
            chk("stag_idle", {31'd0, io.result_valid}, 0);
        end
        io.rhs_valid = 1'b1;
        #1 chk("stag_fire", {30'd0, io.lhs_ready, io.rhs_ready}, 32'd3);
        tick();
        io.rhs_valid = 1'b0;
        io.lhs = 8'd200;
        #1 chk("stag_busy_rdy", {30'd0, io.lhs_ready, io.rhs_ready}, 0);
        io.lhs_valid = 1'b0;
        wait_valid(n);
        chk("stag_lat", n, 8);
        chk("stag_q", {24'd0, io.result}, 15);
        tick();

        io.lhs = 8'd50;
        io.rhs = 8'd5;
        io.lhs_valid = 1'b1;
        io.rhs_valid = 1'b1;
        tick();
        io.lhs = 8'd81;
        io.rhs = 8'd9;
        wait_valid(n);
        chk("b2b_lat0", n, 8);
        chk("b2b_q0", {24'd0, io.result}, 10);
        chk("b2b_overlap", {30'd0, io.lhs_ready, io.rhs_ready}, 32'd3);
        tick();
        io.lhs_valid = 1'b0;
        io.rhs_valid = 1'b0;
        wait_valid(n);
        chk("b2b_lat1", n, 8);
        chk("b2b_q1", {24'd0, io.result}, 9);
        tick();

        io.lhs = 8'd100;
        io.rhs = 8'd7;
        io.lhs_valid = 1'b1;
        io.rhs_valid = 1'b1;
        tick();
        io.lhs_valid = 1'b0;
        io.rhs_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", {31'd0, io.result_valid}, 0);
        op(8'd9, 8'd3, 3, "after_rst");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
